// File: rtl/aes_axis_wrapper.sv
// AES-128 ECB encryption engine between an AXI4-Stream command/data source and
// an AXI4-Stream result sink. One round per cycle; round keys are expanded on
// the fly from the stored key for every block. Byte k of a key/block/result
// lives in bits [8k+7:8k] of the 128-bit vectors, so stream word w maps
// directly onto bits [32w+31:32w].
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CMD   | waiting for the command word of a request packet
// ST_KEY   | loading four key words into the key register
// ST_DATA  | collecting the four words of a plaintext block
// ST_ROUND | running AES rounds 1..10, one per cycle
// ST_OUT   | presenting the four ciphertext words to the sink
module aes_axis_wrapper (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s00_axis_tdata,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic        s00_axis_tlast,
  output logic [31:0] m00_axis_tdata,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic        m00_axis_tlast
);

  typedef enum logic [2:0] {ST_CMD, ST_KEY, ST_DATA, ST_ROUND, ST_OUT} state_t;

  state_t       state, state_nxt;
  logic [127:0] key_reg;
  logic [127:0] blk;
  logic [127:0] rkey;
  logic [127:0] rk_nxt;
  logic [127:0] blk_rnd;
  logic [3:0]   round;
  logic [1:0]   cnt;
  logic         last_flag;
  logic         s_hs;
  logic         m_hs;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (0 maps to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Word 0 of the key holds the first key byte in its low bits, so RotWord
  // is a right rotation by one byte and Rcon lands in bits [7:0].
  function automatic logic [127:0] next_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({rk[103:96], rk[127:104]}) ^ {24'h0, rc};
    n0 = rk[31:0] ^ t;
    n1 = rk[63:32] ^ n0;
    n2 = rk[95:64] ^ n1;
    n3 = rk[127:96] ^ n2;
    return {n3, n2, n1, n0};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last_rnd);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) sb[k] = sbox(s[8*k +: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last_rnd) begin
        o[32*c +: 32] = {a3, a2, a1, a0};
      end else begin
        o[32*c +: 32] = {xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3),
                         a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                         a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                         xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3};
      end
    end
    return o ^ rk;
  endfunction

  assign s_hs    = s00_axis_tvalid & s00_axis_tready;
  assign m_hs    = m00_axis_tvalid & m00_axis_tready;
  assign rk_nxt  = next_key(rkey, rcon(round));
  assign blk_rnd = aes_round(blk, rk_nxt, round == 4'd10);

  // Input is only accepted while collecting; reset forces ready low immediately.
  assign s00_axis_tready = aresetn & ((state == ST_CMD) | (state == ST_KEY) | (state == ST_DATA));
  assign m00_axis_tvalid = (state == ST_OUT);
  assign m00_axis_tdata  = m00_axis_tvalid ? blk[{cnt, 5'b0} +: 32] : 32'h0;
  assign m00_axis_tlast  = m00_axis_tvalid & (cnt == 2'd3) & last_flag;

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_CMD;
    else          state <= state_nxt;
  end

  // Next-state decode from stream handshakes and round count.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CMD: begin
        if (s_hs && !s00_axis_tlast) state_nxt = s00_axis_tdata[0] ? ST_KEY : ST_DATA;
      end
      ST_KEY: begin
        if (s_hs) begin
          if (s00_axis_tlast)   state_nxt = ST_CMD;
          else if (cnt == 2'd3) state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (s_hs) begin
          if (cnt == 2'd3)         state_nxt = ST_ROUND;
          else if (s00_axis_tlast) state_nxt = ST_CMD;
        end
      end
      ST_ROUND: begin
        if (round == 4'd10) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        if (m_hs && cnt == 2'd3) state_nxt = last_flag ? ST_CMD : ST_DATA;
      end
      default: state_nxt = ST_CMD;
    endcase
  end

  // Key/block capture, round iteration and output word index.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      key_reg   <= '0;
      blk       <= '0;
      rkey      <= '0;
      round     <= '0;
      cnt       <= '0;
      last_flag <= 1'b0;
    end else begin
      case (state)
        ST_CMD: cnt <= '0;
        ST_KEY: begin
          if (s_hs) begin
            key_reg[{cnt, 5'b0} +: 32] <= s00_axis_tdata;
            cnt <= s00_axis_tlast ? 2'd0 : cnt + 2'd1;
          end
        end
        ST_DATA: begin
          if (s_hs) begin
            if (cnt == 2'd3) begin
              blk       <= {s00_axis_tdata, blk[95:0]} ^ key_reg;
              rkey      <= key_reg;
              round     <= 4'd1;
              last_flag <= s00_axis_tlast;
              cnt       <= '0;
            end else begin
              blk[{cnt, 5'b0} +: 32] <= s00_axis_tdata;
              cnt <= s00_axis_tlast ? 2'd0 : cnt + 2'd1;
            end
          end
        end
        ST_ROUND: begin
          blk   <= blk_rnd;
          rkey  <= rk_nxt;
          round <= round + 4'd1;
        end
        ST_OUT: begin
          if (m_hs) cnt <= cnt + 2'd1;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_axis_wrapper.sv
module tb_aes_axis_wrapper;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;

  aes_axis_wrapper dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  int           checks = 0;
  int           failures = 0;
  beat_t        exp_q[$];
  logic [7:0]   sbox_t[256];
  logic [127:0] model_key = '0;
  int           tready_mode = 0;
  bit           gaps = 0;

  localparam logic [127:0] KEY1 = {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [127:0] PT1  = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
  localparam logic [127:0] CT1  = {32'h5ac5b470, 32'h80b7cdd8, 32'h30047b6a, 32'hd8e0c469};
  localparam logic [127:0] KEYB = {32'h3c4fcf09, 32'h8815f7ab, 32'ha6d2ae28, 32'h16157e2b};
  localparam logic [127:0] PTB  = {32'h340737e0, 32'ha2983131, 32'h8d305a88, 32'ha8f64332};
  localparam logic [127:0] CTB  = {32'h320b6a19, 32'h978511dc, 32'hfb09dc02, 32'h1d842539};
  localparam logic [127:0] CT0  = {32'h2e2b34ca, 32'h59fa4c88, 32'h3b2c8aef, 32'hd44be966};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box table by exhaustive inverse search and bitwise affine transform.
  task automatic build_sbox();
    logic [7:0] inv, c, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gm(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  // Textbook AES-128: full key schedule up front, then ten rounds on a byte array.
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   rk [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tmp [4];
    logic [7:0]   a [4];
    logic [7:0]   h, rc;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) rk[i] = key[8*i +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = rk[4*(i-1)+j];
      if (i % 4 == 0) begin
        h = tmp[0];
        tmp[0] = sbox_t[tmp[1]] ^ rc;
        tmp[1] = sbox_t[tmp[2]];
        tmp[2] = sbox_t[tmp[3]];
        tmp[3] = sbox_t[h];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) rk[4*i+j] = rk[4*i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rk[i];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4*c+w] = sbox_t[s[4*((c+w)%4)+w]];
      for (int c = 0; c < 4; c++) begin
        for (int w = 0; w < 4; w++) a[w] = t[4*c+w];
        for (int w = 0; w < 4; w++) begin
          if (r < 10)
            s[4*c+w] = xt(a[w]) ^ xt(a[(w+1)%4]) ^ a[(w+1)%4] ^ a[(w+2)%4] ^ a[(w+3)%4];
          else
            s[4*c+w] = a[w];
          s[4*c+w] = s[4*c+w] ^ rk[16*r+4*c+w];
        end
      end
    end
    for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
    return o;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic l);
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge aclk);
      #1;
    end
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (s_tready) break;
      n++;
      if (n > 3000) begin
        chk("input_ready_timeout", 64'(s_tready), 64'd1);
        finish_run();
      end
    end
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_blk(input logic [127:0] pt, input logic l, input logic use_ct,
                          input logic [127:0] ct);
    logic [127:0] e;
    e = use_ct ? ct : aes_ref(model_key, pt);
    for (int w = 0; w < 4; w++) send_word(pt[32*w +: 32], l && (w == 3));
    for (int w = 0; w < 4; w++) exp_q.push_back({e[32*w +: 32], l && (w == 3)});
  endtask

  task automatic send_key(input logic [127:0] k, input logic l);
    for (int w = 0; w < 4; w++) send_word(k[32*w +: 32], l && (w == 3));
    model_key = k;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
  endtask

  // Sink-side ready generation.
  initial begin
    int phase;
    phase = 0;
    forever begin
      @(posedge aclk);
      #1;
      case (tready_mode)
        1:       m_tready = (phase % 8) >= 2;
        2:       m_tready = ($urandom_range(0, 1) == 1);
        default: m_tready = 1'b1;
      endcase
      phase++;
    end
  end

  // Monitor: pops expected beats on handshakes, checks hold-under-backpressure
  // and that no input is accepted while output is pending.
  initial begin
    beat_t       b;
    logic        pend;
    logic [33:0] prev;
    pend = 0;
    prev = '0;
    forever begin
      @(negedge aclk);
      if (aresetn) begin
        if (pend) chk("hold_stable", 64'({m_tvalid, m_tlast, m_tdata}), 64'(prev));
        if (m_tvalid) chk("in_ready_during_out", 64'(s_tready), 64'd0);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%0h required=none at %0t", m_tdata, $time);
          end else begin
            b = exp_q.pop_front();
            chk("out_data", 64'(m_tdata), 64'(b.d));
            chk("out_last", 64'(m_tlast), 64'(b.l));
          end
        end
        pend = m_tvalid && !m_tready;
        prev = {m_tvalid, m_tlast, m_tdata};
      end else begin
        pend = 0;
      end
    end
  end

  initial begin
    #900000;
    checks++;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    finish_run();
  end

  initial begin
    logic         ld;
    int           nb;
    logic [31:0]  cmd;
    logic [127:0] k, pt;

    build_sbox();

    // Reset values.
    repeat (2) @(negedge aclk);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast",  64'(m_tlast),  64'd0);
    chk("rst_m_tdata",  64'(m_tdata),  64'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("ready_after_rst", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;

    // Key load + one block with latency measurement.
    send_word(32'h00000001, 1'b0);
    send_key(KEY1, 1'b0);
    for (int w = 0; w < 3; w++) send_word(PT1[32*w +: 32], 1'b0);
    send_word(PT1[127:96], 1'b1);
    for (int w = 0; w < 4; w++) exp_q.push_back({CT1[32*w +: 32], w == 3});
    for (int n = 1; n <= 10; n++) begin
      @(posedge aclk);
      #1;
      chk("latency_valid", 64'(m_tvalid), 64'(n == 10));
      if (n < 10) chk("round_ready_low", 64'(s_tready), 64'd0);
    end
    drain();

    // Key reuse, three blocks in one packet.
    send_word(32'h00000000, 1'b0);
    for (int b = 0; b < 3; b++) send_blk(PT1, b == 2, 1'b1, CT1);
    drain();

    // Sink backpressure: 2 low / 6 high.
    tready_mode = 1;
    send_word(32'hfffffffe, 1'b0);
    send_blk(PT1, 1'b0, 1'b1, CT1);
    send_blk(~PT1, 1'b1, 1'b0, '0);
    drain();
    tready_mode = 0;

    // FIPS-197 appendix B vector.
    send_word(32'h00000001, 1'b0);
    send_key(KEYB, 1'b0);
    send_blk(PTB, 1'b1, 1'b1, CTB);
    drain();

    // Truncated data block: no output, then a full request.
    send_word(32'h00000001, 1'b0);
    send_key(KEY1, 1'b0);
    send_word(PT1[31:0], 1'b0);
    send_word(PT1[63:32], 1'b1);
    repeat (20) @(posedge aclk);
    #1;
    chk("trunc_back_to_cmd", 64'(s_tready), 64'd1);
    send_word(32'h00000000, 1'b0);
    send_blk(PT1, 1'b1, 1'b1, CT1);
    drain();

    // Key truncated after two words: only the low half is replaced.
    k = {$urandom, $urandom, $urandom, $urandom};
    send_word(32'h00000001, 1'b0);
    send_word(k[31:0], 1'b0);
    send_word(k[63:32], 1'b1);
    model_key[63:0] = k[63:0];
    send_word(32'h00000000, 1'b0);
    send_blk(PT1, 1'b1, 1'b0, '0);
    drain();

    // Randomized packets with input gaps and random sink ready.
    gaps = 1;
    tready_mode = 2;
    for (int p = 0; p < 24; p++) begin
      ld  = ($urandom_range(0, 1) == 1);
      nb  = $urandom_range(0, 3);
      cmd = $urandom;
      cmd[0] = ld;
      send_word(cmd, !ld && nb == 0);
      if (ld) begin
        k = {$urandom, $urandom, $urandom, $urandom};
        send_key(k, nb == 0);
      end
      for (int b = 0; b < nb; b++) begin
        pt = {$urandom, $urandom, $urandom, $urandom};
        send_blk(pt, b == nb - 1, 1'b0, '0);
      end
    end
    drain();
    gaps = 0;
    tready_mode = 0;

    // Reset in the middle of the rounds: abort, key cleared.
    send_word(32'h00000001, 1'b0);
    send_key(KEY1, 1'b0);
    for (int w = 0; w < 4; w++) send_word(PT1[32*w +: 32], w == 3);
    repeat (5) @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_s_tready", 64'(s_tready), 64'd0);
    chk("midrst_m_tdata",  64'(m_tdata),  64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    model_key = '0;
    @(negedge aclk);
    chk("ready_after_midrst", 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1;
    send_word(32'h00000000, 1'b0);
    send_blk('0, 1'b1, 1'b1, CT0);
    drain();

    finish_run();
  end

endmodule
